// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA octet-string conversion blocks.
package rsa_pkg;
    localparam int RSA_WIDTH = 2048;

    typedef logic [7:0] octet_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CONVERT,
        DONE
    } i2osp_state_t;
endpackage

// File: rtl/i2osp_range_check.sv
// Combinational "integer too large" test: flags len beyond NOCT or any set bit of x above octet len-1.
module i2osp_range_check
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int NOCT  = WIDTH / 8,
    parameter int LW    = $clog2(NOCT) + 1
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [LW-1:0]    len_i,
    output logic             too_large_o
);
    localparam logic [LW-1:0] NOCT_L = LW'(NOCT);

    logic [31:0] shamt;

    // Shifting by 8*len leaves exactly the octets that do not fit in len octets.
    assign shamt       = 32'(len_i) << 3;
    assign too_large_o = (len_i > NOCT_L) || ((x_i >> shamt) != '0);
endmodule

// File: rtl/i2osp.sv
// I2OSP: converts x into a big-endian octet string of len octets, one octet per cycle.
// Define I2OSP_RANGE_CHECK_EN to report oversized x / len as an error instead of truncating.
module i2osp
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int NOCT  = WIDTH / 8,
    parameter int LW    = $clog2(NOCT) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             valid,
    output logic             error,
    output logic [WIDTH-1:0] X,
    output i2osp_state_t     dbg_state
);
    i2osp_state_t     state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] X_q, X_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             error_q, error_d;
    logic [LW-1:0]    pos;
    octet_t           oct;

`ifdef I2OSP_RANGE_CHECK_EN
    logic too_large;

    i2osp_range_check #(
        .WIDTH (WIDTH),
        .NOCT  (NOCT),
        .LW    (LW)
    ) u_range_check (
        .x_i         (x_q),
        .len_i       (len_q),
        .too_large_o (too_large)
    );
`else
    localparam logic [LW-1:0] NOCT_L = LW'(NOCT);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            X_q     <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            X_q     <= X_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        X_d     = X_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        // x_q is shifted down each CONVERT cycle, so its low octet is always octet cnt_q of x.
        oct     = x_q[7:0];
        pos     = len_q - cnt_q - LW'(1);

        case (state_q)
            IDLE: begin
                if (ready) begin
                    x_d     = x;
                    len_d   = len;
                    X_d     = '0;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
`ifdef I2OSP_RANGE_CHECK_EN
                if (too_large) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = CONVERT;
                end
`else
                if (len_q > NOCT_L) begin
                    len_d = NOCT_L;
                end
                state_d = (len_q == '0) ? DONE : CONVERT;
`endif
            end
            CONVERT: begin
                X_d   = X_q | (WIDTH'(oct) << {pos, 3'b000});
                x_d   = x_q >> 8;
                cnt_d = cnt_q + LW'(1);
                if (cnt_q == len_q - LW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign valid     = (state_q == DONE);
    assign error     = error_q;
    assign X         = X_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_i2osp.sv
// Self-checking bench for i2osp (WIDTH=64, NOCT=8); follows I2OSP_RANGE_CHECK_EN when defined.
module tb_i2osp;
    import rsa_pkg::*;

    localparam int WIDTH = 64;
    localparam int NOCT  = 8;
    localparam int LW    = 4;
    localparam int W     = WIDTH + 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             ready = 1'b0;
    logic [LW-1:0]    len   = '0;
    logic [WIDTH-1:0] x     = '0;
    logic             busy;
    logic             valid;
    logic             error;
    logic [WIDTH-1:0] X;
    i2osp_state_t     dbg_state;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    i2osp #(.WIDTH(WIDTH), .NOCT(NOCT), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .len       (len),
        .x         (x),
        .busy      (busy),
        .valid     (valid),
        .error     (error),
        .X         (X),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [63:0] xv, input int lv);
        logic [63:0] r   = '0;
        logic        err = 1'b0;
        int          l   = lv;
`ifdef I2OSP_RANGE_CHECK_EN
        if (l > NOCT) err = 1'b1;
        else if (l < NOCT && (xv >> (8 * l)) != 64'd0) err = 1'b1;
`else
        if (l > NOCT) l = NOCT;
`endif
        if (!err) begin
            for (int k = 0; k < l; k++) begin
                r = r | (64'(8'(xv >> (8 * k))) << (8 * (l - 1 - k)));
            end
        end
        return {err, r};
    endfunction

    function automatic int exp_lat(input logic [63:0] xv, input int lv);
        logic [W-1:0] m = model(xv, lv);
        int           l = (lv > NOCT) ? NOCT : lv;
        return (m[W-1] || l == 0) ? 2 : l + 2;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one request and returns just after its capture edge.
    task automatic send(input logic [63:0] xv, input logic [LW-1:0] lv);
        @(negedge clk);
        x     = xv;
        len   = lv;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    // Edges counted with the capture edge as edge 1; -1 means valid never came.
    task automatic wait_valid(output int edges);
        edges = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (valid) return;
        end
        edges = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, valid, error, X} !== '0 || dbg_state !== IDLE) begin
            $display("FAIL reset_outputs: got busy=%b valid=%b error=%b X=%h state=%0d, want all 0 / IDLE",
                     busy, valid, error, X, dbg_state);
        end else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0]  tx [8];
        int           tl [8];
        logic [W-1:0] te [8];
        int           tlat [8];
        logic [W-1:0] obs;
        logic [W-1:0] got;
        int           edges;

        tx[0] = 64'h04030201;         tl[0] = 4; te[0] = {1'b0, 64'h01020304};         tlat[0] = 6;
        tx[1] = 64'h0102;             tl[1] = 4; te[1] = {1'b0, 64'h02010000};         tlat[1] = 6;
        tx[3] = 64'h0;                tl[3] = 0; te[3] = {1'b0, 64'h0};                tlat[3] = 2;
        tx[4] = 64'h0807060504030201; tl[4] = 8; te[4] = {1'b0, 64'h0102030405060708}; tlat[4] = 10;
        tx[6] = 64'h1122;             tl[6] = 2; te[6] = {1'b0, 64'h2211};             tlat[6] = 4;
        tx[2] = 64'h01000000;         tl[2] = 3;
        tx[5] = 64'hAA;               tl[5] = 9;
        tx[7] = 64'h112233;           tl[7] = 2;
`ifdef I2OSP_RANGE_CHECK_EN
        te[2] = {1'b1, 64'h0}; tlat[2] = 2;
        te[5] = {1'b1, 64'h0}; tlat[5] = 2;
        te[7] = {1'b1, 64'h0}; tlat[7] = 2;
`else
        te[2] = {1'b0, 64'h0};                tlat[2] = 5;
        te[5] = {1'b0, 64'hAA00000000000000}; tlat[5] = 10;
        te[7] = {1'b0, 64'h3322};             tlat[7] = 4;
`endif
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(te[i]);
            lat_q.push_back(tlat[i]);
            send(tx[i], LW'(tl[i]));
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_after_capture[%0d]: got %b want 1", i, busy);
            else n_pass++;
            wait_valid(edges);
            obs = {error, X};
            got = exp_q.pop_front();
            n_checks++;
            if (edges !== lat_q.pop_front()) $display("FAIL latency[%0d]: got %0d edges want %0d", i, edges, tlat[i]);
            else n_pass++;
            n_checks++;
            if (obs !== got) $display("FAIL result[%0d]: got error=%b X=%h want error=%b X=%h",
                                      i, obs[W-1], obs[WIDTH-1:0], got[W-1], got[WIDTH-1:0]);
            else n_pass++;
            x = ~x;
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b0 || {error, X} !== obs)
                $display("FAIL hold[%0d]: got valid=%b error=%b X=%h want valid=0 error=%b X=%h",
                         i, valid, error, X, obs[W-1], obs[WIDTH-1:0]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [63:0]  xv;
        int           lv;
        int           edges;
        int           want_lat;
        logic [W-1:0] want;
        for (int i = 0; i < 10; i++) begin
            xv = {$urandom, $urandom};
            lv = $urandom_range(9, 0);
            if ($urandom_range(1, 0) == 1 && lv < NOCT) xv = xv & ((64'd1 << (8 * lv)) - 64'd1);
            exp_q.push_back(model(xv, lv));
            lat_q.push_back(exp_lat(xv, lv));
            send(xv, LW'(lv));
            wait_valid(edges);
            want     = exp_q.pop_front();
            want_lat = lat_q.pop_front();
            n_checks++;
            if (edges !== want_lat || {error, X} !== want)
                $display("FAIL random[%0d] x=%h len=%0d: got edges=%0d error=%b X=%h want edges=%0d error=%b X=%h",
                         i, xv, lv, edges, error, X, want_lat, want[W-1], want[WIDTH-1:0]);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_convert();
        int           seen = 0;
        int           edges;
        logic [W-1:0] want;
        send(64'h1122334455667788, LW'(8));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, valid, error, X} !== '0 || dbg_state !== IDLE)
            $display("FAIL mid_convert_reset: got busy=%b valid=%b error=%b X=%h want all 0", busy, valid, error, X);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL no_valid_after_reset: got %0d pulses want 0", seen);
        else n_pass++;
        exp_q.push_back({1'b0, 64'hCDAB});
        send(64'hABCD, LW'(2));
        wait_valid(edges);
        want = exp_q.pop_front();
        n_checks++;
        if (edges !== 4 || {error, X} !== want)
            $display("FAIL after_reset_req: got edges=%0d error=%b X=%h want edges=4 error=%b X=%h",
                     edges, error, X, want[W-1], want[WIDTH-1:0]);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0]   xv;
        logic [W-1:0] want;
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            xv    = 8'($urandom_range(255, 0));
            x     = {56'h0, xv};
            len   = LW'(1);
            ready = 1'b1;
            if (t % 4 == 0) exp_q.push_back({1'b0, 56'h0, xv});
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== (t % 4 == 2)) $display("FAIL b2b_valid[%0d]: got %b want %b", t, valid, (t % 4 == 2));
            else n_pass++;
            if (valid && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_checks++;
                if ({error, X} !== want)
                    $display("FAIL b2b_data[%0d]: got error=%b X=%h want error=%b X=%h",
                             t, error, X, want[W-1], want[WIDTH-1:0]);
                else n_pass++;
            end
        end
        @(negedge clk);
        ready = 1'b0;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size());
        else n_pass++;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_convert();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
